register_file_rename: RTL and testbench

- Architectural register file with per-register rename tags; the consumer end of the ROB commit/forwarding interface.
- Accepts in-order commit writes from the reorder buffer and records the ROB index producing each register at dispatch.
- Resolves source operands for the instruction unit: committed value, ROB-forwarded value, or dependency tag.
- Drops all rename state on a misprediction clear.

---
 rtl/register_file_rename.sv | 172 +++++++++++++++++
 tb/tb_register_file_rename.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_rename.sv
// register_file_rename: architectural register file with per-register rename
// tags. It takes in-order commit writes from the ROB and records which ROB
// entry will produce each register. Each source operand resolves to one of
// three things: the committed value, a value forwarded from the ROB, or a
// dependency tag.
// Optional trace output is enabled with the REG_FILE_TRACE_EN macro.

// One source-operand resolver. It is instantiated once per read port.
module registerReadPort #(
    parameter int ROB_WIDTH = 4,
    parameter int IDX_W     = 5
) (
    input  logic [IDX_W-1:0]     srcIndex,
    input  logic                 entryBusy,
    input  logic [ROB_WIDTH-1:0] entryTag,
    input  logic [31:0]          entryValue,
    input  logic                 commitValid,
    input  logic [IDX_W-1:0]     commitDest,
    input  logic [ROB_WIDTH-1:0] commitRobId,
    input  logic [31:0]          commitValue,
    input  logic                 robReady,
    input  logic [31:0]          robValue,
    output logic                 srcReady,
    output logic [31:0]          srcValue,
    output logic [ROB_WIDTH-1:0] srcDep,
    output logic [ROB_WIDTH-1:0] robDep
);
    logic commitHit;
    assign commitHit = commitValid && (commitDest == srcIndex) && (commitRobId == entryTag);

    // The ROB lookup always uses the recorded tag, so the ROB sees a stable
    // request whichever branch of the priority chain below is taken.
    assign robDep = entryTag;

    // Priority: x0, then the committed value, then the commit bypass, then
    // the ROB forward, and finally the dependency tag.
    always_comb begin
        srcReady = 1'b1;
        srcValue = '0;
        srcDep   = '0;
        if (srcIndex == '0) begin
            srcReady = 1'b1;
        end else if (!entryBusy) begin
            srcValue = entryValue;
        end else if (commitHit) begin
            srcValue = commitValue;
        end else if (robReady) begin
            srcValue = robValue;
        end else begin
            srcReady = 1'b0;
            srcDep   = entryTag;
        end
    end
endmodule

module register_file_rename #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_COUNT = 32,
    parameter int IDX_W     = $clog2(REG_COUNT)
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clear,
    input  logic                 commitValid,
    input  logic [IDX_W-1:0]     commitDest,
    input  logic [31:0]          commitValue,
    input  logic [ROB_WIDTH-1:0] commitRobId,
    input  logic                 renameValid,
    input  logic [IDX_W-1:0]     renameDest,
    input  logic [ROB_WIDTH-1:0] renameRobId,
    input  logic [IDX_W-1:0]     rs1Index,
    input  logic [IDX_W-1:0]     rs2Index,
    output logic [ROB_WIDTH-1:0] robRs1Dep,
    input  logic                 robRs1Ready,
    input  logic [31:0]          robRs1Value,
    output logic [ROB_WIDTH-1:0] robRs2Dep,
    input  logic                 robRs2Ready,
    input  logic [31:0]          robRs2Value,
    output logic                 rs1Ready,
    output logic [31:0]          rs1Value,
    output logic [ROB_WIDTH-1:0] rs1Dep,
    output logic                 rs2Ready,
    output logic [31:0]          rs2Value,
    output logic [ROB_WIDTH-1:0] rs2Dep
);
    localparam int NUM_SRC = 2;

    logic [REG_COUNT-1:0][31:0]          valueQ;
    logic [REG_COUNT-1:0]                busyQ;
    logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tagQ;

    logic commitWr;
    logic renameWr;
    assign commitWr = commitValid && (commitDest != '0);
    assign renameWr = renameValid && !clear && (renameDest != '0);

    // Commits always write the value, even to a register that a younger
    // producer already owns.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) valueQ <= '0;
        else if (commitWr) valueQ[commitDest] <= commitValue;
    end

    // Busy and tag update. A commit releases the register only if it is the
    // current owner. A rename in the same cycle overrides the commit, and a
    // clear drops all ownership while keeping the tags.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            busyQ <= '0;
            tagQ  <= '0;
        end else if (clear) begin
            busyQ <= '0;
        end else begin
            if (commitWr && busyQ[commitDest] && (tagQ[commitDest] == commitRobId))
                busyQ[commitDest] <= 1'b0;
            if (renameWr) begin
                busyQ[renameDest] <= 1'b1;
                tagQ[renameDest]  <= renameRobId;
            end
        end
    end

    logic [NUM_SRC-1:0][IDX_W-1:0]     srcIndex;
    logic [NUM_SRC-1:0]                srcRobReady;
    logic [NUM_SRC-1:0][31:0]          srcRobValue;
    logic [NUM_SRC-1:0]                srcReady;
    logic [NUM_SRC-1:0][31:0]          srcValue;
    logic [NUM_SRC-1:0][ROB_WIDTH-1:0] srcDep;
    logic [NUM_SRC-1:0][ROB_WIDTH-1:0] srcRobDep;

    assign srcIndex    = {rs2Index, rs1Index};
    assign srcRobReady = {robRs2Ready, robRs1Ready};
    assign srcRobValue = {robRs2Value, robRs1Value};

    for (genvar s = 0; s < NUM_SRC; s++) begin : gPort
        registerReadPort #(.ROB_WIDTH(ROB_WIDTH), .IDX_W(IDX_W)) uPort (
            .srcIndex    (srcIndex[s]),
            .entryBusy   (busyQ[srcIndex[s]]),
            .entryTag    (tagQ[srcIndex[s]]),
            .entryValue  (valueQ[srcIndex[s]]),
            .commitValid (commitValid),
            .commitDest  (commitDest),
            .commitRobId (commitRobId),
            .commitValue (commitValue),
            .robReady    (srcRobReady[s]),
            .robValue    (srcRobValue[s]),
            .srcReady    (srcReady[s]),
            .srcValue    (srcValue[s]),
            .srcDep      (srcDep[s]),
            .robDep      (srcRobDep[s])
        );
    end

    assign rs1Ready  = srcReady[0];
    assign rs1Value  = srcValue[0];
    assign rs1Dep    = srcDep[0];
    assign robRs1Dep = srcRobDep[0];
    assign rs2Ready  = srcReady[1];
    assign rs2Value  = srcValue[1];
    assign rs2Dep    = srcDep[1];
    assign robRs2Dep = srcRobDep[1];

`ifdef REG_FILE_TRACE_EN
    // Simulation trace of accepted commits and flushes.
    always @(posedge clockIn) begin
        if (!resetIn && commitWr)
            $display("REG: x%0d <= %h (rob %0d)", commitDest, commitValue, commitRobId);
        if (!resetIn && clear)
            $display("REG: flush");
    end
`endif
endmodule

// File: tb/tb_register_file_rename.sv
// Self-checking bench for register_file_rename. It contains directed scenarios
// and a randomized run, both checked against a register-level reference model.
module tb_register_file_rename;
    logic        clockIn = 1'b0;
    logic        resetIn = 1'b1;
    logic        clear, commitValid, renameValid;
    logic [4:0]  commitDest, renameDest, rs1Index, rs2Index;
    logic [31:0] commitValue, robRs1Value, robRs2Value;
    logic [3:0]  commitRobId, renameRobId;
    logic        robRs1Ready, robRs2Ready;
    logic [3:0]  robRs1Dep, robRs2Dep, rs1Dep, rs2Dep;
    logic        rs1Ready, rs2Ready;
    logic [31:0] rs1Value, rs2Value;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents, the owning ROB entry (if any) and the last recorded tag.
    logic [31:0] mv   [32];
    bit          mbusy[32];
    logic [3:0]  mtag [32];

    register_file_rename dut (
        .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
        .commitValid(commitValid), .commitDest(commitDest), .commitValue(commitValue),
        .commitRobId(commitRobId), .renameValid(renameValid), .renameDest(renameDest),
        .renameRobId(renameRobId), .rs1Index(rs1Index), .rs2Index(rs2Index),
        .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
        .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
        .rs1Ready(rs1Ready), .rs1Value(rs1Value), .rs1Dep(rs1Dep),
        .rs2Ready(rs2Ready), .rs2Value(rs2Value), .rs2Dep(rs2Dep)
    );

    always #5 clockIn = ~clockIn;

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin mv[i] = '0; mbusy[i] = 0; mtag[i] = '0; end
    endtask

    task automatic idle();
        clear = 0; commitValid = 0; renameValid = 0;
        commitDest = '0; commitValue = '0; commitRobId = '0;
        renameDest = '0; renameRobId = '0;
        rs1Index = '0; rs2Index = '0;
        robRs1Ready = 0; robRs2Ready = 0; robRs1Value = '0; robRs2Value = '0;
    endtask

    // Apply the architectural effect of the current inputs, then cross the edge.
    task automatic step();
        if (commitValid && commitDest != 0) begin
            mv[commitDest] = commitValue;
            if (mbusy[commitDest] && mtag[commitDest] == commitRobId) mbusy[commitDest] = 0;
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
        end else if (renameValid && renameDest != 0) begin
            mbusy[renameDest] = 1;
            mtag[renameDest]  = renameRobId;
        end
        @(posedge clockIn);
        #1;
    endtask

    // Operand resolution as seen by the instruction unit.
    task automatic modelRead(input int r, input logic rr, input logic [31:0] rv,
                             output logic rdy, output logic [31:0] val,
                             output logic [3:0] dep, output logic [3:0] rdep);
        rdep = mtag[r];
        rdy = 1; val = '0; dep = '0;
        if (r == 0) ;
        else if (!mbusy[r]) val = mv[r];
        else if (commitValid && commitDest == r && commitRobId == mtag[r]) val = commitValue;
        else if (rr) val = rv;
        else begin rdy = 0; dep = mtag[r]; end
    endtask

    task automatic test_reset();
        idle();
        rs1Index = 5; rs2Index = 0;
        #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h0 || rs1Dep !== 4'h0) begin
            errors++; $display("FAIL reset_rs1: got rdy=%b val=%h dep=%h want 1/0/0", rs1Ready, rs1Value, rs1Dep); end
        checks++; if (rs2Ready !== 1'b1 || rs2Value !== 32'h0 || rs2Dep !== 4'h0) begin
            errors++; $display("FAIL reset_rs2: got rdy=%b val=%h dep=%h want 1/0/0", rs2Ready, rs2Value, rs2Dep); end
        resetIn = 0;
        step();
    endtask

    task automatic test_rename_dep();
        idle(); renameValid = 1; renameDest = 3; renameRobId = 2;
        step();
        idle(); rs1Index = 3; #1;
        checks++; if (rs1Ready !== 1'b0 || rs1Dep !== 4'd2 || robRs1Dep !== 4'd2 || rs1Value !== 32'h0) begin
            errors++; $display("FAIL rename_dep: got rdy=%b dep=%h robDep=%h val=%h want 0/2/2/0", rs1Ready, rs1Dep, robRs1Dep, rs1Value); end
        robRs1Ready = 1; robRs1Value = 32'h55; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h55 || rs1Dep !== 4'h0) begin
            errors++; $display("FAIL rob_forward: got rdy=%b val=%h dep=%h want 1/55/0", rs1Ready, rs1Value, rs1Dep); end
        idle(); clear = 1; step();
    endtask

    task automatic test_younger_producer();
        idle(); renameValid = 1; renameDest = 3; renameRobId = 2; step();
        renameRobId = 7; step();
        idle(); commitValid = 1; commitDest = 3; commitValue = 32'h11; commitRobId = 2; step();
        idle(); rs1Index = 3; #1;
        checks++; if (rs1Ready !== 1'b0 || rs1Dep !== 4'd7) begin
            errors++; $display("FAIL younger_owner: got rdy=%b dep=%h want 0/7", rs1Ready, rs1Dep); end
        clear = 1; step();
        idle(); rs1Index = 3; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h11) begin
            errors++; $display("FAIL stale_commit_value: got rdy=%b val=%h want 1/11", rs1Ready, rs1Value); end
    endtask

    task automatic test_bypass();
        idle(); renameValid = 1; renameDest = 4; renameRobId = 5; step();
        idle(); commitValid = 1; commitDest = 4; commitValue = 32'hABCD; commitRobId = 5;
        rs1Index = 4; robRs1Ready = 1; robRs1Value = 32'hDEAD; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'hABCD || rs1Dep !== 4'h0) begin
            errors++; $display("FAIL commit_bypass: got rdy=%b val=%h dep=%h want 1/abcd/0", rs1Ready, rs1Value, rs1Dep); end
        step();
        idle(); rs1Index = 4; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'hABCD) begin
            errors++; $display("FAIL bypass_after: got rdy=%b val=%h want 1/abcd", rs1Ready, rs1Value); end
    endtask

    task automatic test_clear();
        idle(); commitValid = 1;
        commitDest = 6; commitValue = 32'h66; step();
        commitDest = 7; commitValue = 32'h77; step();
        commitDest = 8; commitValue = 32'h88; step();
        idle(); renameValid = 1; renameDest = 6; renameRobId = 1; step();
        renameDest = 7; renameRobId = 2; step();
        clear = 1; renameDest = 8; renameRobId = 3; step();
        idle(); rs1Index = 6; rs2Index = 7; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h66 || rs2Ready !== 1'b1 || rs2Value !== 32'h77) begin
            errors++; $display("FAIL clear_x6_x7: got %b/%h %b/%h want 1/66 1/77", rs1Ready, rs1Value, rs2Ready, rs2Value); end
        rs1Index = 8; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h88 || rs1Dep !== 4'h0) begin
            errors++; $display("FAIL clear_drops_rename: got rdy=%b val=%h dep=%h want 1/88/0", rs1Ready, rs1Value, rs1Dep); end
    endtask

    task automatic test_x0();
        idle(); commitValid = 1; commitDest = 0; commitValue = 32'h99; commitRobId = 4;
        renameValid = 1; renameDest = 0; renameRobId = 4; step();
        idle(); rs2Index = 0; robRs2Ready = 1; robRs2Value = 32'h123; #1;
        checks++; if (rs2Ready !== 1'b1 || rs2Value !== 32'h0 || rs2Dep !== 4'h0 || robRs2Dep !== 4'h0) begin
            errors++; $display("FAIL x0_read: got rdy=%b val=%h dep=%h robDep=%h want 1/0/0/0", rs2Ready, rs2Value, rs2Dep, robRs2Dep); end
    endtask

    task automatic test_same_cycle();
        idle(); renameValid = 1; renameDest = 5; renameRobId = 3; step();
        // Commit of the current owner together with a new rename: the rename wins.
        idle(); commitValid = 1; commitDest = 5; commitValue = 32'h5A5A; commitRobId = 3;
        renameValid = 1; renameDest = 5; renameRobId = 9; step();
        idle(); rs1Index = 5; #1;
        checks++; if (rs1Ready !== 1'b0 || rs1Dep !== 4'd9) begin
            errors++; $display("FAIL rename_wins: got rdy=%b dep=%h want 0/9", rs1Ready, rs1Dep); end
        // A source that matches its own destination sees the older state.
        idle(); commitValid = 1; commitDest = 10; commitValue = 32'hA0; step();
        idle(); renameValid = 1; renameDest = 10; renameRobId = 6; rs1Index = 10; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'hA0) begin
            errors++; $display("FAIL read_before_rename: got rdy=%b val=%h want 1/a0", rs1Ready, rs1Value); end
        step();
        idle(); clear = 1; step();
        idle(); rs1Index = 5; #1;
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h5A5A) begin
            errors++; $display("FAIL same_cycle_value: got rdy=%b val=%h want 1/5a5a", rs1Ready, rs1Value); end
    endtask

    task automatic test_random();
        logic        er1, er2;
        logic [31:0] ev1, ev2;
        logic [3:0]  ed1, ed2, erd1, erd2;
        for (int n = 0; n < 300; n++) begin
            clear       = ($urandom_range(15) == 0);
            commitValid = $urandom_range(1);
            commitDest  = 5'($urandom_range(7));
            commitValue = $urandom;
            commitRobId = $urandom_range(1) ? mtag[commitDest] : 4'($urandom);
            renameValid = $urandom_range(1);
            renameDest  = 5'($urandom_range(7));
            renameRobId = 4'($urandom);
            rs1Index    = 5'($urandom_range(7));
            rs2Index    = 5'($urandom_range(7));
            robRs1Ready = ($urandom_range(3) == 0);
            robRs2Ready = ($urandom_range(3) == 0);
            robRs1Value = $urandom;
            robRs2Value = $urandom;
            #1;
            modelRead(rs1Index, robRs1Ready, robRs1Value, er1, ev1, ed1, erd1);
            modelRead(rs2Index, robRs2Ready, robRs2Value, er2, ev2, ed2, erd2);
            checks++; if (rs1Ready !== er1 || rs1Value !== ev1 || rs1Dep !== ed1 || robRs1Dep !== erd1) begin
                errors++; $display("FAIL rand_rs1 n=%0d x%0d: got %b/%h/%h/%h want %b/%h/%h/%h", n, rs1Index,
                    rs1Ready, rs1Value, rs1Dep, robRs1Dep, er1, ev1, ed1, erd1); end
            checks++; if (rs2Ready !== er2 || rs2Value !== ev2 || rs2Dep !== ed2 || robRs2Dep !== erd2) begin
                errors++; $display("FAIL rand_rs2 n=%0d x%0d: got %b/%h/%h/%h want %b/%h/%h/%h", n, rs2Index,
                    rs2Ready, rs2Value, rs2Dep, robRs2Dep, er2, ev2, ed2, erd2); end
            step();
        end
    endtask

    task automatic test_async_reset();
        idle(); commitValid = 1; commitDest = 9; commitValue = 32'h9999; step();
        idle(); renameValid = 1; renameDest = 9; renameRobId = 4; step();
        // Assert reset away from the clock edge; the effect must be immediate.
        idle(); rs1Index = 9; resetIn = 1; #1;
        modelReset();
        checks++; if (rs1Ready !== 1'b1 || rs1Value !== 32'h0 || rs1Dep !== 4'h0 || robRs1Dep !== 4'h0) begin
            errors++; $display("FAIL async_reset: got %b/%h/%h/%h want 1/0/0/0", rs1Ready, rs1Value, rs1Dep, robRs1Dep); end
        resetIn = 0;
        step();
    endtask

    initial begin
        modelReset();
        idle();
        test_reset();
        test_rename_dep();
        test_younger_producer();
        test_bypass();
        test_clear();
        test_x0();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
